mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter AW, default 10, meaning word-address bits used (array depth 2^AW x 16); Addr[15:AW] ignored.
REQ-002 SHALL have parameter RD_LAT, default 2, legal 2..8, meaning cycles from read acceptance to RdValid.
REQ-003 SHALL have parameter WB_DEPTH, default 4, meaning posted write-buffer entries.
REQ-004 Clk1  in  1  sole clock; all state on rising edge.
REQ-005 Reset_n  in  1  asynchronous, active-low reset.
REQ-006 Addr  in  16  word address from initiator.
REQ-007 RD  in  1  read request.
REQ-008 WR  in  1  write request.
REQ-009 DataIn  in  16  write data from initiator.
REQ-010 DataOut  out  16  read data to initiator.
REQ-011 Ready  out  1  request accepted on the next rising edge if high.
REQ-012 RdValid  out  1  one-cycle pulse; DataOut valid.
REQ-013 WbEmpty  out  1  write buffer empty and no drain pending.
REQ-014 Err  out  1  sticky protocol-error flag.

Function
REQ-015 Acceptance SHALL occur at a rising edge where Ready=1 and (RD|WR)=1.
REQ-016 Ready SHALL be 1 only in IDLE with buffer count < WB_DEPTH, or in RESP with count < WB_DEPTH.
REQ-017 Read FSM SHALL have states IDLE, RWAIT, RESP: accepted RD in IDLE/RESP -> RWAIT with counter=RD_LAT-1; RWAIT decrements, counter=1 -> RESP; RESP -> IDLE unless a new RD is accepted.
REQ-018 RdValid SHALL be 1 exactly in RESP, i.e. sampled high at edge k+RD_LAT for acceptance edge k; back-to-back reads SHALL complete every RD_LAT cycles.
REQ-019 Read data SHALL be captured at acceptance: the youngest write-buffer entry with matching Addr[AW-1:0] if any, else the array word.
REQ-020 DataOut SHALL update only when entering RESP and SHALL hold between reads.
REQ-021 Accepted WR SHALL push {Addr[AW-1:0], DataIn} into the buffer; no response pulse.
REQ-022 Buffer SHALL drain the oldest entry into the array one per cycle, except on a read-acceptance edge (array port busy).
REQ-023 Push and drain on the same edge SHALL leave count unchanged; count SHALL never exceed WB_DEPTH or underflow.
REQ-024 RD=WR=1 when accepted SHALL perform the write only and set Err; Err cleared only by reset.
REQ-025 RD/WR while Ready=0 SHALL be ignored (initiator must hold).
REQ-026 Buffer pointers SHALL wrap modulo WB_DEPTH.

Reset
REQ-027 Reset_n low SHALL asynchronously force: FSM IDLE, counter 0, buffer empty, DataOut 0, RdValid 0, Err 0, Ready 1, WbEmpty 1.
REQ-028 Reset mid-read SHALL discard the read (no RdValid); undrained writes SHALL be lost; array contents SHALL NOT be reset.

Structure
REQ-029 Package mem_resp_pkg SHALL hold the state enum (IDLE, RWAIT, RESP) and default AW/RD_LAT/WB_DEPTH constants.
REQ-030 Write buffer with address-match lookup SHALL be sub-module mem_wbuf; FSM and array in mem_responder.

Verification
REQ-031 Write 0x1234 to 0x0010, idle 6 cycles, read 0x0010 -> RdValid at edge k+2, DataOut=0x1234, WbEmpty=1 before the read.
REQ-032 Write 0xAAAA then 0xBBBB to 0x0020 on consecutive edges, read 0x0020 on the next edge -> DataOut=0xBBBB (forwarded).
REQ-033 Five writes on consecutive edges with a read accepted mid-burst -> Ready drops while count=4, no write lost, final readback of all 5 correct.
REQ-034 RD=WR=1 at 0x0030 with data 0x5555 -> Err=1, no RdValid, later read of 0x0030 returns 0x5555.
REQ-035 Reset_n low one cycle after read acceptance -> no RdValid, DataOut=0, Ready=1; pre-reset drained data intact.
REQ-036 RD_LAT=4, three back-to-back reads -> RdValid pulses exactly 4 cycles apart with correct data.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared types and default parameters for the memory responder.
package mem_resp_pkg;

    localparam int unsigned DefAw      = 10;
    localparam int unsigned DefRdLat   = 2;
    localparam int unsigned DefWbDepth = 4;
    localparam int unsigned DataW      = 16;

    // Read-side FSM states.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRwait = 2'd1,
        StResp  = 2'd2
    } rd_state_e;

endpackage

// File: rtl/mem_wbuf.sv
// Posted write buffer: circular FIFO of {addr, data} with youngest-match lookup
// so reads can be forwarded data that has not yet reached the array.
module mem_wbuf
    import mem_resp_pkg::*;
#(
    parameter int unsigned AW    = DefAw,
    parameter int unsigned Depth = DefWbDepth,
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [AW-1:0]    push_addr_i,
    input  logic [DataW-1:0] push_data_i,
    input  logic             pop_i,
    input  logic [AW-1:0]    lookup_addr_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW-1:0]    head_addr_o,
    output logic [DataW-1:0] head_data_o,
    output logic             hit_o,
    output logic [DataW-1:0] hit_data_o
);

    logic [AW-1:0]    addr_q [Depth];
    logic [DataW-1:0] data_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;
    logic [PtrW-1:0]  idx;

    // Pointers wrap modulo Depth, which need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(Depth - 1)) begin
            return '0;
        end
        return p + PtrW'(1);
    endfunction

    assign full_o      = (count_q == CntW'(Depth));
    assign empty_o     = (count_q == '0);
    assign do_push     = push_i && !full_o;
    assign do_pop      = pop_i && !empty_o;
    assign head_addr_o = addr_q[rd_ptr_q];
    assign head_data_o = data_q[rd_ptr_q];

    // Next-state for pointers and occupancy; push+pop leaves count unchanged.
    always_comb begin
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are meaningless outside the occupied window.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            addr_q[wr_ptr_q] <= push_addr_i;
            data_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        hit_o      = 1'b0;
        hit_data_o = '0;
        idx        = '0;
        for (int unsigned i = 0; i < Depth; i++) begin
            idx = PtrW'((32'(rd_ptr_q) + i) % Depth);
            if ((i < 32'(count_q)) && (addr_q[idx] == lookup_addr_i)) begin
                hit_o      = 1'b1;
                hit_data_o = data_q[idx];
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Word-addressed memory responder: fixed-latency reads with write-buffer
// forwarding, posted writes drained into the array when its port is free.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned AW       = DefAw,
    parameter int unsigned RD_LAT   = DefRdLat,
    parameter int unsigned WB_DEPTH = DefWbDepth
) (
    input  logic             Clk1,
    input  logic             Reset_n,
    input  logic [15:0]      Addr,
    input  logic             RD,
    input  logic             WR,
    input  logic [DataW-1:0] DataIn,
    output logic [DataW-1:0] DataOut,
    output logic             Ready,
    output logic             RdValid,
    output logic             WbEmpty,
    output logic             Err
);

    localparam int unsigned LatW = $clog2(RD_LAT);

    rd_state_e        state_q, state_d;
    logic [LatW-1:0]  lat_cnt_q, lat_cnt_d;
    logic [DataW-1:0] rd_data_q, rd_data_d;
    logic [DataW-1:0] dout_q, dout_d;
    logic             err_q, err_d;
    logic [DataW-1:0] mem_q [2**AW];

    logic [AW-1:0]    addr_lo;
    logic             accept, wr_accept, rd_accept, drain;
    logic             wb_full, wb_empty, wb_hit;
    logic [AW-1:0]    wb_head_addr;
    logic [DataW-1:0] wb_head_data, wb_hit_data;

    assign addr_lo = Addr[AW-1:0];

    // Upper address bits are intentionally ignored.
    if (AW < 16) begin : gen_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^Addr[15:AW];
    end

    // RD with WR is treated as a write; the read half is dropped.
    assign accept    = Ready && (RD || WR);
    assign wr_accept = accept && WR;
    assign rd_accept = accept && RD && !WR;
    // The array port belongs to the read lookup on a read-acceptance edge.
    assign drain     = !wb_empty && !rd_accept;

    mem_wbuf #(
        .AW    (AW),
        .Depth (WB_DEPTH)
    ) u_wbuf (
        .clk_i         (Clk1),
        .rst_ni        (Reset_n),
        .push_i        (wr_accept),
        .push_addr_i   (addr_lo),
        .push_data_i   (DataIn),
        .pop_i         (drain),
        .lookup_addr_i (addr_lo),
        .full_o        (wb_full),
        .empty_o       (wb_empty),
        .head_addr_o   (wb_head_addr),
        .head_data_o   (wb_head_data),
        .hit_o         (wb_hit),
        .hit_data_o    (wb_hit_data)
    );

    // FSM state register.
    always_ff @(posedge Clk1 or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= StIdle;
            lat_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
        end
    end

    // FSM next state: RWAIT counts down so RESP lands RD_LAT-1 edges after acceptance.
    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        unique case (state_q)
            StIdle, StResp: begin
                if (rd_accept) begin
                    state_d   = StRwait;
                    lat_cnt_d = LatW'(RD_LAT - 1);
                end else begin
                    state_d = StIdle;
                end
            end
            StRwait: begin
                if (lat_cnt_q == LatW'(1)) begin
                    state_d   = StResp;
                    lat_cnt_d = '0;
                end else begin
                    lat_cnt_d = lat_cnt_q - LatW'(1);
                end
            end
            default: begin
                state_d   = StIdle;
                lat_cnt_d = '0;
            end
        endcase
    end

    // FSM outputs.
    always_comb begin
        Ready   = ((state_q == StIdle) || (state_q == StResp)) && !wb_full;
        RdValid = (state_q == StResp);
    end

    // Capture read data at acceptance; publish it only on entry to RESP.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_accept) begin
            rd_data_d = wb_hit ? wb_hit_data : mem_q[addr_lo];
        end
        dout_d = ((state_q == StRwait) && (state_d == StResp)) ? rd_data_q : dout_q;
        err_d  = err_q || (accept && RD && WR);
    end

    // Datapath and sticky error registers.
    always_ff @(posedge Clk1 or negedge Reset_n) begin
        if (!Reset_n) begin
            rd_data_q <= '0;
            dout_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            rd_data_q <= rd_data_d;
            dout_q    <= dout_d;
            err_q     <= err_d;
        end
    end

    // Array write port fed by the buffer head; contents survive reset.
    always_ff @(posedge Clk1) begin
        if (drain) begin
            mem_q[wb_head_addr] <= wb_head_data;
        end
    end

    assign DataOut = dout_q;
    assign WbEmpty = wb_empty;
    assign Err     = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (RD_LAT 2 and 4) share stimulus and
// are checked every cycle against a timing/queue model, plus directed checks.
module tb_mem_responder;

    localparam int WB = 4;

    typedef struct packed {
        logic [9:0]  a;
        logic [15:0] d;
    } wr_t;

    logic        Clk1, Reset_n, RD, WR;
    logic [15:0] Addr, DataIn;
    logic [15:0] dout_w [2];
    logic [1:0]  ready_w, rdv_w, wbe_w, err_w;

    mem_responder #(.AW(10), .RD_LAT(2), .WB_DEPTH(WB)) u_dut_lat2 (
        .Clk1(Clk1), .Reset_n(Reset_n), .Addr(Addr), .RD(RD), .WR(WR), .DataIn(DataIn),
        .DataOut(dout_w[0]), .Ready(ready_w[0]), .RdValid(rdv_w[0]), .WbEmpty(wbe_w[0]),
        .Err(err_w[0])
    );

    mem_responder #(.AW(10), .RD_LAT(4), .WB_DEPTH(WB)) u_dut_lat4 (
        .Clk1(Clk1), .Reset_n(Reset_n), .Addr(Addr), .RD(RD), .WR(WR), .DataIn(DataIn),
        .DataOut(dout_w[1]), .Ready(ready_w[1]), .RdValid(rdv_w[1]), .WbEmpty(wbe_w[1]),
        .Err(err_w[1])
    );

    int checks = 0;
    int failures = 0;

    // Model: per instance, edge of last read acceptance, pending data, buffer queue, array.
    int          cyc = 0;
    int          lat_m [2] = '{2, 4};
    int          rd_k [2];
    logic [15:0] rd_pend [2];
    logic [15:0] dout_m [2];
    logic        err_m [2];
    wr_t         wq [2][$];
    logic [15:0] mem_m [2][1024];
    bit          rdy_m [2];
    bit          acc_m, rd_acc_m;
    logic [15:0] val_m;

    bit          mon_en = 0;
    int          pulse_t [$];
    logic [15:0] pulse_d [$];

    initial begin
        Clk1 = 1'b0;
        forever #5 Clk1 = ~Clk1;
    end

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        check(name, {15'b0, got}, {15'b0, exp});
    endtask

    // After edge cyc: free once the pending read has reached its response cycle.
    function automatic bit exp_ready(input int i);
        return (cyc >= rd_k[i] + lat_m[i] - 1) && (wq[i].size() < WB);
    endfunction

    function automatic bit exp_rdvalid(input int i);
        return cyc == rd_k[i] + lat_m[i] - 1;
    endfunction

    // Reference model, advanced on every edge.
    initial begin
        for (int i = 0; i < 2; i++) begin
            rd_k[i] = -100; rd_pend[i] = '0; dout_m[i] = '0; err_m[i] = 1'b0;
        end
        forever begin
            @(posedge Clk1 or negedge Reset_n);
            if (!Reset_n) begin
                for (int i = 0; i < 2; i++) begin
                    wq[i].delete();
                    rd_k[i] = -100; dout_m[i] = '0; err_m[i] = 1'b0;
                end
            end else begin
                for (int i = 0; i < 2; i++) rdy_m[i] = exp_ready(i);
                cyc++;
                for (int i = 0; i < 2; i++) begin
                    acc_m    = rdy_m[i] && (RD || WR);
                    rd_acc_m = acc_m && RD && !WR;
                    if (rd_acc_m) begin
                        val_m = mem_m[i][Addr[9:0]];
                        for (int j = 0; j < wq[i].size(); j++) begin
                            if (wq[i][j].a == Addr[9:0]) val_m = wq[i][j].d;
                        end
                        rd_k[i]    = cyc;
                        rd_pend[i] = val_m;
                    end
                    if (!rd_acc_m && wq[i].size() > 0) begin
                        mem_m[i][wq[i][0].a] = wq[i][0].d;
                        void'(wq[i].pop_front());
                    end
                    if (acc_m && WR) wq[i].push_back({Addr[9:0], DataIn});
                    if (acc_m && RD && WR) err_m[i] = 1'b1;
                    if (cyc == rd_k[i] + lat_m[i] - 1) dout_m[i] = rd_pend[i];
                end
            end
        end
    end

    // Every-cycle comparison, mid-cycle on the falling edge.
    initial begin
        forever begin
            @(negedge Clk1);
            for (int i = 0; i < 2; i++) begin
                chk1($sformatf("ready%0d", i), ready_w[i], exp_ready(i));
                chk1($sformatf("rdvalid%0d", i), rdv_w[i], exp_rdvalid(i));
                chk1($sformatf("wbempty%0d", i), wbe_w[i], wq[i].size() == 0);
                chk1($sformatf("err%0d", i), err_w[i], err_m[i]);
                check($sformatf("dataout%0d", i), dout_w[i], dout_m[i]);
            end
            if (mon_en && rdv_w[1] === 1'b1) begin
                pulse_t.push_back(cyc);
                pulse_d.push_back(dout_w[1]);
            end
        end
    end

    task automatic idle(input int n);
        RD = 1'b0; WR = 1'b0;
        repeat (n) @(negedge Clk1);
    endtask

    task automatic step(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [15:0] d);
        RD = rd; WR = wr; Addr = a; DataIn = d;
        @(negedge Clk1);
        RD = 1'b0; WR = 1'b0;
    endtask

    // Hold a request until instance `which` shows Ready, then let it be accepted.
    task automatic req(input int which, input logic rd, input logic wr,
                       input logic [15:0] a, input logic [15:0] d);
        int n;
        n = 0;
        RD = rd; WR = wr; Addr = a; DataIn = d;
        while (ready_w[which] !== 1'b1 && n < 20) begin
            @(negedge Clk1);
            n++;
        end
        checks++;
        if (n >= 20) begin
            failures++;
            $display("FAIL req_timeout got=Ready0 exp=Ready1 inst=%0d", which);
        end
        @(negedge Clk1);
        RD = 1'b0; WR = 1'b0;
    endtask

    initial begin
        Reset_n = 1'b1; RD = 1'b0; WR = 1'b0; Addr = '0; DataIn = '0;
        #1 Reset_n = 1'b0;
        @(negedge Clk1);
        @(negedge Clk1);
        chk1("rst_ready", ready_w[0], 1'b1);
        chk1("rst_wbempty", wbe_w[0], 1'b1);
        chk1("rst_rdvalid", rdv_w[0], 1'b0);
        check("rst_dataout", dout_w[0], 16'h0000);
        chk1("rst_err", err_w[0], 1'b0);
        #1 Reset_n = 1'b1;
        @(negedge Clk1);

        // Write, let it drain, read back.
        step(1'b0, 1'b1, 16'h0010, 16'h1234);
        idle(6);
        chk1("wbempty_before_rd", wbe_w[0], 1'b1);
        step(1'b1, 1'b0, 16'h0010, 16'h0000);
        chk1("rd_not_early", rdv_w[0], 1'b0);
        idle(1);
        chk1("rd_valid_k2", rdv_w[0], 1'b1);
        check("rd_data_1234", dout_w[0], 16'h1234);
        idle(8);

        // Forwarding of the youngest buffered write.
        step(1'b0, 1'b1, 16'h0020, 16'hAAAA);
        step(1'b0, 1'b1, 16'h0020, 16'hBBBB);
        step(1'b1, 1'b0, 16'h0020, 16'h0000);
        idle(1);
        chk1("fwd_valid", rdv_w[0], 1'b1);
        check("fwd_data", dout_w[0], 16'hBBBB);
        idle(8);

        // Write burst with a read in the middle, then read everything back.
        for (int j = 0; j < 5; j++) begin
            if (j == 2) begin
                req(0, 1'b1, 1'b0, 16'h0020, 16'h0000);
                chk1("ready_drop_rwait", ready_w[0], 1'b0);
            end
            req(0, 1'b0, 1'b1, 16'h0040 + 16'(j), 16'hC000 + 16'(j));
        end
        idle(4);
        for (int j = 0; j < 5; j++) begin
            req(0, 1'b1, 1'b0, 16'h0040 + 16'(j), 16'h0000);
            idle(1);
            check($sformatf("burst_rb%0d", j), dout_w[0], 16'hC000 + 16'(j));
        end
        idle(8);

        // RD and WR together: write only, sticky error.
        req(0, 1'b1, 1'b1, 16'h0030, 16'h5555);
        idle(1);
        chk1("rdwr_err", err_w[0], 1'b1);
        chk1("rdwr_no_valid", rdv_w[0], 1'b0);
        idle(4);
        req(0, 1'b1, 1'b0, 16'h0030, 16'h0000);
        idle(1);
        check("rdwr_data", dout_w[0], 16'h5555);
        idle(8);

        // Reset one cycle after a read is accepted.
        req(0, 1'b0, 1'b1, 16'h0050, 16'h7777);
        idle(4);
        req(0, 1'b1, 1'b0, 16'h0050, 16'h0000);
        #1 Reset_n = 1'b0;
        #1;
        chk1("midrd_rdvalid", rdv_w[0], 1'b0);
        check("midrd_dataout", dout_w[0], 16'h0000);
        chk1("midrd_ready", ready_w[0], 1'b1);
        chk1("midrd_err", err_w[0], 1'b0);
        @(negedge Clk1);
        #1 Reset_n = 1'b1;
        idle(3);
        req(0, 1'b1, 1'b0, 16'h0050, 16'h0000);
        idle(1);
        check("post_rst_data", dout_w[0], 16'h7777);
        idle(8);

        // Back-to-back reads on the RD_LAT=4 instance.
        pulse_t.delete();
        pulse_d.delete();
        mon_en = 1'b1;
        req(1, 1'b1, 1'b0, 16'h0010, 16'h0000);
        req(1, 1'b1, 1'b0, 16'h0020, 16'h0000);
        req(1, 1'b1, 1'b0, 16'h0030, 16'h0000);
        idle(8);
        mon_en = 1'b0;
        check("lat4_pulses", 16'(pulse_t.size()), 16'd3);
        if (pulse_t.size() == 3) begin
            check("lat4_gap01", 16'(pulse_t[1] - pulse_t[0]), 16'd4);
            check("lat4_gap12", 16'(pulse_t[2] - pulse_t[1]), 16'd4);
            check("lat4_d0", pulse_d[0], 16'h1234);
            check("lat4_d1", pulse_d[1], 16'hBBBB);
            check("lat4_d2", pulse_d[2], 16'h5555);
        end

        // Random traffic over a small, fully initialised address window.
        for (int j = 0; j < 16; j++) begin
            step(1'b0, 1'b1, {6'($urandom), 6'b0, 4'(j)}, 16'($urandom));
        end
        idle(4);
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                RD = 1'b0; WR = 1'b0;
                #1 Reset_n = 1'b0;
                @(negedge Clk1);
                #1 Reset_n = 1'b1;
                @(negedge Clk1);
            end else begin
                RD     = ($urandom_range(0, 2) == 0);
                WR     = ($urandom_range(0, 2) == 0);
                Addr   = {6'($urandom), 6'b0, 4'($urandom)};
                DataIn = 16'($urandom);
                @(negedge Clk1);
            end
        end
        idle(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
